// File: rtl/fifo_class_if.sv
// Lane-side bus for the per-class FIFO: write strobe/data in, registered read data and level flags out.
interface fifo_class_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_class.sv
// Per-class synchronous FIFO downstream of the class demux: in-order storage, registered read,
// count-decoded level flags and sticky overflow/underflow error flags.
module fifo_class #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic          clk,
    input  logic          reset_L,
    fifo_class_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic full_c, empty_c, wr_en_c, rd_en_c;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == CW'(0));
    // A pop frees a slot in the same edge, so push+pop on a full FIFO still stores the word.
    assign wr_en_c = bus.push && (!full_c || bus.pop);
    assign rd_en_c = bus.pop && !empty_c;

    // Next-state for pointers, count, read register and sticky errors
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({wr_en_c, rd_en_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (bus.push && full_c && !bus.pop) begin
            ovf_d = 1'b1;
        end
        if (bus.pop && empty_c) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage array carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.valid_out     = valid_q;
    assign bus.full          = full_c;
    assign bus.empty         = empty_c;
    assign bus.almost_full   = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty  = (count_q <= CW'(AE_THRESH));
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
endmodule
